// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encodings and funct codes for the multicycle MIPS core
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } md_state_t;

  // Funct codes the control unit decodes to raise MultStart / DivStart
  localparam logic [5:0] MULTFunct = 6'b011000;
  localparam logic [5:0] DIVFunct  = 6'b011010;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-divide iteration on {rem,quot}
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so the shifted trial fits in WIDTH+1 bits
  assign trial = {rem, quot[WIDTH-1]};
  assign diff  = trial - {1'b0, divisor};

  always_comb begin
    if (diff[WIDTH]) begin
      rem_next  = trial[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end else begin
      rem_next  = diff[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div.sv
// rtl/mult_div.sv - multi-cycle signed MULT/DIV unit with HI/LO registers
// Optional MULTDIV_FAST_ZERO_EN: zero-operand operations skip the iteration phase.
module mult_div
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(ITER) + 1;

  md_state_t state, next_state;

  // acc holds {P,Q,q-1} for MULT and {rem,quot,0} for DIV
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    counter;
  logic             is_div, q_neg, r_neg;

  logic             accept, take_mult, take_div, take_dz, fast_zero, last_step;
  logic [WIDTH-1:0] p, q, a_mag, b_mag, rem_next, quot_next;
  logic [WIDTH:0]   booth_sum;

  assign p = acc[2*WIDTH:WIDTH+1];
  assign q = acc[WIDTH:1];

  assign accept    = (state == S_IDLE) || (state == S_DONE);
  assign take_mult = accept && MultStart;
  assign take_div  = accept && !MultStart && DivStart && (B != '0);
  assign take_dz   = accept && !MultStart && DivStart && (B == '0);
  assign last_step = (counter == CW'(ITER - 1));
  assign a_mag     = A[WIDTH-1] ? -A : A;
  assign b_mag     = B[WIDTH-1] ? -B : B;

`ifdef MULTDIV_FAST_ZERO_EN
  assign fast_zero = (take_mult && ((A == '0) || (B == '0))) || (take_div && (A == '0));
`else
  assign fast_zero = 1'b0;
`endif

  // Sum is kept one bit wider so P - (-2^(WIDTH-1)) cannot lose its sign
  always_comb begin
    booth_sum = {p[WIDTH-1], p};
    case ({q[0], acc[0]})
      2'b01:   booth_sum = {p[WIDTH-1], p} + {m[WIDTH-1], m};
      2'b10:   booth_sum = {p[WIDTH-1], p} - {m[WIDTH-1], m};
      default: booth_sum = {p[WIDTH-1], p};
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (p),
    .quot     (q),
    .divisor  (m),
    .rem_next (rem_next),
    .quot_next(quot_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (fast_zero)      next_state = S_FIX;
        else if (take_mult) next_state = S_MULT;
        else if (take_div)  next_state = S_DIV;
        else                next_state = S_IDLE;
      end
      S_MULT: begin
        busy = 1'b1;
        if (last_step) next_state = S_FIX;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_step) next_state = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      m        <= '0;
      counter  <= '0;
      is_div   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= take_dz;
      if (take_mult || take_div || take_dz) begin
        counter <= '0;
        if (take_mult) begin
          is_div <= 1'b0;
          m      <= A;
          acc    <= fast_zero ? '0 : {{WIDTH{1'b0}}, B, 1'b0};
        end else if (take_div) begin
          is_div <= 1'b1;
          q_neg  <= A[WIDTH-1] ^ B[WIDTH-1];
          r_neg  <= A[WIDTH-1];
          m      <= b_mag;
          acc    <= {{WIDTH{1'b0}}, a_mag, 1'b0};
        end
      end else if (state == S_MULT) begin
        acc     <= {booth_sum, q};
        counter <= counter + 1'b1;
      end else if (state == S_DIV) begin
        acc     <= {rem_next, quot_next, 1'b0};
        counter <= counter + 1'b1;
      end else if (state == S_FIX) begin
        if (is_div) begin
          HI <= r_neg ? -p : p;
          LO <= q_neg ? -q : q;
        end else begin
          HI <= p;
          LO <= q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - randomized self-checking bench for mult_div against an arithmetic model
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MultStart = 1'b0;
  logic        DivStart = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI, LO;
  logic        busy, done, div_zero;

  int checks = 0;
  int failures = 0;

  mult_div dut (
    .clk(clk), .reset(reset), .MultStart(MultStart), .DivStart(DivStart),
    .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) return 64'(sa * sb);
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  function automatic int exp_latency(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_FAST_ZERO_EN
    if (is_mult && (a == 0 || b == 0)) return 1;
    if (!is_mult && a == 0) return 1;
`endif
    return 33;
  endfunction

  // Issue one operation, follow it to done, check latency, busy and HI/LO
  task automatic run_op(input string tag, input bit is_mult, input bit both,
                        input logic [31:0] a, input logic [31:0] b);
    int k;
    bit busy_bad;
    @(negedge clk);
    MultStart = is_mult | both;
    DivStart  = !is_mult | both;
    A = a;
    B = b;
    @(posedge clk);
    @(negedge clk);
    MultStart = 1'b0;
    DivStart  = 1'b0;
    A = $urandom;
    B = $urandom;
    k = 0;
    busy_bad = 0;
    while (!done && k < 100) begin
      if (!busy) busy_bad = 1;
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(exp_latency(is_mult, a, b)));
    check({tag, "_busy"}, 64'(busy_bad), 64'(0));
    check({tag, "_hilo"}, {HI, LO}, model(is_mult, a, b));
    @(negedge clk);
    check({tag, "_done_clr"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [31:0] corner [5];
    logic [31:0] ra, rb;
    bit          mop;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", {HI, LO}, 64'h0);
    check("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);
    reset = 1'b0;

    run_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFFFFFD);
    check("mul_7x-3_abs", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("mul_min", 1, 0, 32'h80000000, 32'h80000000);
    check("mul_min_abs", {HI, LO}, 64'h40000000_00000000);
    run_op("div_-7_2", 0, 0, 32'hFFFFFFF9, 32'd2);
    check("div_-7_2_abs", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf", 0, 0, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_abs", {HI, LO}, 64'h00000000_80000000);
    run_op("both_start", 1, 1, 32'd6, 32'd5);

    run_op("div_68_7", 0, 0, 32'd68, 32'd7);
    @(negedge clk);
    DivStart = 1'b1;
    A = 32'd123;
    B = 32'd0;
    @(posedge clk);
    @(negedge clk);
    DivStart = 1'b0;
    check("dz_pulse", {62'h0, div_zero, busy}, 64'h2);
    @(negedge clk);
    check("dz_clr", 64'(div_zero), 64'(0));
    begin
      bit seen_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen_done = 1;
      end
      check("dz_no_done", 64'(seen_done), 64'(0));
    end
    check("dz_hilo", {HI, LO}, 64'h00000005_00000009);

    @(negedge clk);
    MultStart = 1'b1;
    A = 32'd3;
    B = 32'd4;
    @(posedge clk);
    @(negedge clk);
    MultStart = 1'b0;
    repeat (9) @(negedge clk);
    DivStart = 1'b1;
    A = 32'd100;
    B = 32'd3;
    @(negedge clk);
    DivStart = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_hold_hilo", {HI, LO}, 64'h00000005_00000009);
    check("busy_mid", 64'(busy), 64'(1));
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hilo", {HI, LO}, 64'h0);
    check("abort_flags", {61'h0, busy, done, div_zero}, 64'h0);
    run_op("mul_3x4", 1, 0, 32'd3, 32'd4);

    for (int i = 0; i < 24; i++) begin
      mop = $urandom_range(0, 1);
      ra = (i % 3 == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      rb = (i % 4 == 1) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      if (!mop && rb == 0) rb = 32'd3;
      run_op($sformatf("rnd%0d", i), mop, 0, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Multi-cycle signed MULT/DIV responder for the multicycle MIPS core.
- The control unit raises a one-cycle start with operands from the A/B registers, then waits for done or div_zero.
- Results are held in internal HI/LO registers, which are read by the MFHI/MFLO datapath path.
- One iteration per clock: radix-2 Booth multiply, restoring divide.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MultStart  in  1  one-cycle request: signed multiply.
- DivStart  in  1  one-cycle request: signed divide.
- A  in  WIDTH  multiplicand / dividend, sampled on the start edge.
- B  in  WIDTH  multiplier / divisor, sampled on the start edge.
- HI  out  WIDTH  MULT: upper product; DIV: remainder.
- LO  out  WIDTH  MULT: lower product; DIV: quotient.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO valid.
- div_zero  out  1  one-cycle pulse; divide by zero.

Behaviour:
- Reset (sync, active-high, overrides everything including a start in the same cycle):
  - HI=0, LO=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE, start sampled at edge N:
  - Both MultStart and DivStart high: MULT has priority.
  - Operands are captured at edge N.
  - MultStart: go to MULT, busy=1.
  - DivStart with B!=0: go to DIV, busy=1.
  - DivStart with B==0: div_zero=1 for the single cycle after edge N; busy stays 0; HI/LO unchanged; stay in IDLE.
- MULT:
  - Booth step at each edge N+1..N+ITER on a 2*WIDTH+1-bit {P,Q,q-1} register.
  - Arithmetic right shift each step.
  - Next state: FIX.
- DIV:
  - Operate on operand magnitudes.
  - One restoring step per edge N+1..N+ITER.
  - Next state: FIX.
- FIX (edge N+ITER+1):
  - DIV only: negate the quotient if the operand signs differ; give the remainder the dividend's sign (truncation toward zero).
  - Write HI/LO, set done=1, busy=0, go to DONE.
- DONE: done returns to 0 at the next edge; go to IDLE.
- Latency: 33 edges from start to done, with done high in the cycle after edge N+33. A new start is accepted in the DONE cycle.
- Start while busy: ignored, with no effect on the operation in flight or on HI/LO.
- HI/LO change only at FIX or reset; they stay stable during busy and hold the previous result.
- Overflow cases wrap mod 2^WIDTH with no flag:
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - MULT cannot overflow 64 bits.
- Reset mid-operation: abort immediately; all outputs return to their reset values.
- counter is $clog2(ITER)+1 bits wide and cleared on every start.

Optional Feature:
- Macro: MULTDIV_FAST_ZERO_EN.
- Defined:
  - MULT with A==0 or B==0 skips iteration; at edge N it goes directly to FIX with a zero product.
  - DIV with A==0 and B!=0 does the same, giving HI=LO=0.
  - Result: done in the cycle after edge N+1, busy high for one cycle.
- Undefined: all operations take the full 33-edge latency.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings for IDLE/MULT/DIV/FIX/DONE;
  - MULTFunct=6'b011000 and DIVFunct=6'b011010, which the control unit also uses to select start.
- One natural sub-module: div_step, a combinational restoring-divide iteration of {rem,quot} by divisor giving the next {rem,quot}.
- The Booth step stays inline.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3) -> after 33 edges done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high throughout edges N..N+33.
- MULT A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV B=0 with prior HI=5, LO=9 -> div_zero pulse exactly one cycle, busy=0, done never rises, HI=5, LO=9.
- MULT 3×4 with DivStart pulsed at edge N+10 and reset at edge N+20 -> the DivStart is ignored; after the reset edge HI=LO=0 and busy=done=0. A subsequent MULT 3×4 yields LO=12, HI=0.
